quad_step_decoder: RTL and testbench

//   Quadrature (A/B) step decoder that drives an up/down counter's step interface.

---
 rtl/quad_step_decoder.sv | 163 ++++++++++++++++
 tb/tb_quad_step_decoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature A/B step decoder: synchronises and debounces the encoder phases, tracks
// the Gray sequence and emits step pulses with direction, a wrapping position and a sticky error.
module quad_step_decoder #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WIDTH           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clear,
  input  logic             error_clr,
  output logic             step_en,
  output logic             step_dir,
  output logic [WIDTH-1:0] position,
  output logic             error
);

  localparam int unsigned SYNC_W = 2 * SYNC_STAGES;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_P0,
    ST_P1,
    ST_P2,
    ST_P3
  } dec_state_t;

  logic [SYNC_W-1:0] sync_sr;
  logic [1:0]        sync;
  logic [1:0]        sync_q;
  logic [1:0]        filt;
  logic              filt_valid;
  logic              filt_upd;
  logic [CNT_W-1:0]  db_cnt;
  logic [CNT_W-1:0]  db_nxt_c;
  dec_state_t        state;
  dec_state_t        state_nxt;
  logic [1:0]        delta_c;
  logic              step_c;
  logic              up_c;
  logic              illegal_c;

  // Phase pair {A,B} through the synchroniser chain; oldest stage is the usable value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_sr <= '0;
    end else begin
      sync_sr <= {sync_sr[SYNC_W-3:0], quad_a, quad_b};
    end
  end

  assign sync = sync_sr[SYNC_W-1 -: 2];

  // A change in the synchronised value mid-count restarts the stability run at one
  assign db_nxt_c = (sync != sync_q) ? CNT_W'(1) : db_cnt + CNT_W'(1);

  // Debounce: filt only follows sync after DEBOUNCE_CYCLES stable cycles. Before the first
  // acceptance filt is not valid, so the first stable level is always taken. The cycle
  // right after an acceptance does not count, capping the rate at one per DEBOUNCE_CYCLES+1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      filt       <= '0;
      filt_valid <= 1'b0;
      filt_upd   <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync_q   <= sync;
      filt_upd <= 1'b0;
      if (filt_upd || (filt_valid && (sync == filt))) begin
        db_cnt <= '0;
      end else if (db_nxt_c == DB_LIMIT) begin
        filt       <= sync;
        filt_valid <= 1'b1;
        filt_upd   <= 1'b1;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_nxt_c;
      end
    end
  end

  function automatic dec_state_t phase_state(input logic [1:0] ph);
    case (ph)
      2'b00:   return ST_P0;
      2'b01:   return ST_P1;
      2'b11:   return ST_P2;
      default: return ST_P3;
    endcase
  endfunction

  // Position of a tracked phase along the up sequence 00->01->11->10
  function automatic logic [1:0] state_idx(input dec_state_t s);
    case (s)
      ST_P1:   return 2'd1;
      ST_P2:   return 2'd2;
      ST_P3:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Decode the previous -> new phase one edge after each filt update
  always_comb begin
    state_nxt = state;
    delta_c   = 2'd0;
    step_c    = 1'b0;
    up_c      = 1'b0;
    illegal_c = 1'b0;
    if (filt_upd) begin
      state_nxt = phase_state(filt);
      if (state != ST_INIT) begin
        delta_c = state_idx(state_nxt) - state_idx(state);
        case (delta_c)
          2'd1: begin
            step_c = 1'b1;
            up_c   = 1'b1;
          end
          2'd3:    step_c    = 1'b1;
          2'd2:    illegal_c = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Registered outputs; clear beats a coincident step, a new illegal jump beats error_clr
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_en  <= 1'b0;
      step_dir <= 1'b1;
      position <= '0;
      error    <= 1'b0;
    end else begin
      step_en <= step_c;
      if (step_c) begin
        step_dir <= up_c;
      end
      if (clear) begin
        position <= '0;
      end else if (step_c) begin
        position <= up_c ? position + WIDTH'(1) : position - WIDTH'(1);
      end
      if (illegal_c) begin
        error <= 1'b1;
      end else if (error_clr) begin
        error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: a pin-history reference model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_quad_step_decoder;

  localparam int S = 2;
  localparam int D = 4;
  localparam int W = 4;
  localparam int HL = S + D + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         quad_a = 1'b0;
  logic         quad_b = 1'b0;
  logic         clear = 1'b0;
  logic         error_clr = 1'b0;
  logic         step_en;
  logic         step_dir;
  logic [W-1:0] position;
  logic         error;

  quad_step_decoder #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .WIDTH          (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .quad_a   (quad_a),
    .quad_b   (quad_b),
    .clear    (clear),
    .error_clr(error_clr),
    .step_en  (step_en),
    .step_dir (step_dir),
    .position (position),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulses = 0;
  bit cmp_en = 1'b0;
  logic prev_step = 1'b0;

  // Reference model state
  logic [1:0]   hist[$];
  int           m_t;
  bit           m_have;
  bit           m_pend;
  bit           m_init;
  logic [1:0]   m_filt;
  logic [1:0]   m_level;
  logic         exp_step_en;
  logic         exp_dir;
  logic [W-1:0] exp_pos;
  logic         exp_err;

  logic [1:0] down_seq [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
  int         down_pos [5] = '{3, 2, 1, 0, 15};
  logic [1:0] up_seq   [9] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gray code to its rank along the up sequence
  function automatic int gray_rank(input logic [1:0] v);
    return int'({30'd0, v[1], v[1] ^ v[0]});
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < HL; i++) hist.push_back(2'b00);
    m_t         = 0;
    m_have      = 1'b0;
    m_pend      = 1'b0;
    m_init      = 1'b1;
    m_filt      = 2'b00;
    m_level     = 2'b00;
    exp_step_en = 1'b0;
    exp_dir     = 1'b1;
    exp_pos     = '0;
    exp_err     = 1'b0;
  endtask

  task automatic model_edge();
    logic [1:0] v;
    int r;
    bit stp, up, ill, run, fresh;
    m_t++;
    hist.push_front({quad_a, quad_b});
    void'(hist.pop_back());
    stp = 1'b0;
    up  = 1'b0;
    ill = 1'b0;
    if (m_pend) begin
      if (m_init) begin
        m_init = 1'b0;
      end else begin
        r = (gray_rank(m_filt) - gray_rank(m_level) + 4) % 4;
        if (r == 1) begin
          stp = 1'b1;
          up  = 1'b1;
        end else if (r == 3) begin
          stp = 1'b1;
        end else if (r == 2) begin
          ill = 1'b1;
        end
      end
      m_level = m_filt;
      m_pend  = 1'b0;
    end
    exp_step_en = stp;
    if (stp) exp_dir = up;
    if (clear) exp_pos = '0;
    else if (stp) exp_pos = up ? exp_pos + W'(1) : exp_pos - W'(1);
    if (ill) exp_err = 1'b1;
    else if (error_clr) exp_err = 1'b0;
    // The synchronised value seen at this edge is the pin sample from S edges ago;
    // a level is accepted when exactly D consecutive such samples agree and it is new.
    v   = hist[S];
    run = 1'b1;
    for (int i = 1; i < D; i++) if (hist[S+i] != v) run = 1'b0;
    fresh = (m_t == D) || (hist[S+D] != v);
    if (m_t >= D && run && fresh && (!m_have || v != m_filt)) begin
      m_filt = v;
      m_have = 1'b1;
      m_pend = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_edge();
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("step_en", step_en, exp_step_en);
        check("step_dir", step_dir, exp_dir);
        check("position", position, exp_pos);
        check("error", error, exp_err);
        if (step_en === 1'b1) begin
          n_pulses++;
          check("step_gap", prev_step, 1'b0);
        end
        prev_step = step_en;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input logic [1:0] v);
    {quad_a, quad_b} = v;
  endtask

  task automatic phase(input logic [1:0] v);
    set_ab(v);
    cyc(10);
  endtask

  initial begin
    #1 reset = 1'b0;
    cyc(3);
    reset  = 1'b1;
    cmp_en = 1'b1;

    // Idle at 00: init adoption only
    cyc(20);
    check("t1_pos", position, 0);
    check("t1_err", error, 0);
    check("t1_pulses", n_pulses, 0);

    // Up sequence with latency pinned to edge 7
    set_ab(2'b01);
    cyc(6);
    check("t2_lat_e6", step_en, 0);
    cyc(1);
    check("t2_lat_e7", step_en, 1);
    check("t2_pos1", position, 1);
    cyc(3);
    phase(2'b11);
    phase(2'b10);
    phase(2'b00);
    check("t2_pos", position, 4);
    check("t2_dir", step_dir, 1);
    check("t2_pulses", n_pulses, 4);

    // Down sequence with wrap below zero
    for (int i = 0; i < 5; i++) begin
      phase(down_seq[i]);
      check("t3_pos", position, 32'(down_pos[i]));
    end
    check("t3_dir", step_dir, 0);
    check("t3_err", error, 0);
    check("t3_pulses", n_pulses, 9);

    // Short glitch on A is filtered
    set_ab(2'b00);
    cyc(2);
    set_ab(2'b10);
    cyc(15);
    check("t4_pos", position, 15);
    check("t4_pulses", n_pulses, 9);

    // Wrap above max, illegal jumps and error_clr interplay
    phase(2'b00);
    check("t5_wrap_pos", position, 0);
    check("t5_wrap_dir", step_dir, 1);
    phase(2'b11);
    check("t5_jump_err", error, 1);
    check("t5_jump_pos", position, 0);
    check("t5_jump_dir", step_dir, 1);
    check("t5_jump_pulses", n_pulses, 10);
    error_clr = 1'b1;
    cyc(1);
    error_clr = 1'b0;
    check("t5_eclr", error, 0);
    cyc(2);
    phase(2'b01);
    check("t5_down_pos", position, 15);
    check("t5_down_dir", step_dir, 0);
    set_ab(2'b10);
    cyc(6);
    error_clr = 1'b1;
    cyc(1);
    error_clr = 1'b0;
    check("t5_eclr_vs_jump", error, 1);
    check("t5_jump2_step", step_en, 0);
    cyc(3);
    check("t5_jump2_pos", position, 15);
    check("t5_jump2_dir", step_dir, 0);
    check("t5_pulses", n_pulses, 11);

    // Clear alone, count to 9, then clear coincident with a step
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("t6_clear", position, 0);
    for (int i = 0; i < 9; i++) phase(up_seq[i]);
    check("t6_pos9", position, 9);
    check("t6_pulses", n_pulses, 20);
    set_ab(2'b01);
    cyc(6);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("t6_clr_step", step_en, 1);
    check("t6_clr_pos", position, 0);
    check("t6_clr_dir", step_dir, 1);
    cyc(3);
    phase(2'b11);
    check("t6_pos1", position, 1);

    // Asynchronous reset mid-debounce, then init adoption of the held level
    set_ab(2'b10);
    cyc(3);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_step", step_en, 0);
    check("t6_rst_dir", step_dir, 1);
    check("t6_rst_pos", position, 0);
    check("t6_rst_err", error, 0);
    cyc(2);
    reset = 1'b1;
    cyc(20);
    check("t6_init_pos", position, 0);
    check("t6_init_pulses", n_pulses, 22);
    phase(2'b00);
    check("t6_after_pos", position, 1);
    check("t6_after_dir", step_dir, 1);
    check("t6_after_pulses", n_pulses, 23);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
